trig_conditioner: RTL and testbench

// - Upstream front end for the RF pulse sequencer: cleans the raw Arduino trigger pin and issues one start pulse per accepted trigger.
// - Stages: synchroniser -> glitch filter -> rising-edge detect -> arm/holdoff FSM.
// - Guarantees no start while the sequencer is busy or in the post-sequence holdoff. Counts rejected triggers.

---
 rtl/trig_conditioner_if.sv | 24 ++
 rtl/trig_conditioner.sv | 148 ++++++++++++++
 tb/tb_trig_conditioner.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_conditioner_if.sv
// Trigger conditioner signal bundle.
// The master side drives the raw trigger and sequencer status; the slave side
// (the conditioner) returns the start pulse, arm status, filtered level and miss count.
interface trig_conditioner_if #(
   parameter int MISS_W = 16
);
   logic              trig_in;
   logic              seq_busy;
   logic              miss_clr;
   logic              start;
   logic              armed;
   logic              trig_level;
   logic [MISS_W-1:0] miss_count;

   modport master (
      output trig_in, seq_busy, miss_clr,
      input  start, armed, trig_level, miss_count
   );

   modport slave (
      input  trig_in, seq_busy, miss_clr,
      output start, armed, trig_level, miss_count
   );
endinterface

// File: rtl/trig_conditioner.sv
// Trigger conditioner for the RF pulse sequencer.
// The raw trigger pin passes through a synchroniser, then a glitch filter, then
// a rising-edge detector, and finally an arm/holdoff FSM. The FSM issues one start
// pulse per accepted trigger and counts triggers that arrive when it is not armed.
module trig_conditioner #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILT_CYCLES    = 16,
   parameter int HOLDOFF_CYCLES = 24000,
   parameter int MISS_W         = 16
) (
   input logic               clk,
   input logic               rst_n,
   trig_conditioner_if.slave bus
);
   localparam int FCW = $clog2(FILT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_WAITLOW,
      S_ARMED,
      S_FIRE,
      S_BUSY,
      S_HOLDOFF
   } state_t;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   trig_s;
   logic [FCW-1:0]         filt_cnt_reg;
   logic                   trig_level_reg;
   logic                   level_prev_reg;
   logic                   rise_reg;
   logic                   mismatch;
   logic                   filt_done;
   state_t                 state_reg;
   state_t                 state_next;
   logic [31:0]            hold_cnt_reg;
   logic [31:0]            hold_cnt_next;
   logic                   start_int;
   logic                   armed_int;
   logic                   miss;
   logic [MISS_W-1:0]      miss_count_reg;

   // Synchroniser shift chain; resets high so a pin held high is not seen as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '1;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.trig_in};
      end
   end

   assign trig_s    = sync_reg[SYNC_STAGES-1];
   assign mismatch  = (trig_s != trig_level_reg);
   // The FILT_CYCLES-th consecutive mismatching sample commits the new level.
   assign filt_done = mismatch && (filt_cnt_reg == FCW'(FILT_CYCLES - 1));

   // Glitch filter and registered rising-edge flag (high the cycle after the level rises).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_cnt_reg   <= '0;
         trig_level_reg <= 1'b1;
         level_prev_reg <= 1'b1;
         rise_reg       <= 1'b0;
      end else begin
         level_prev_reg <= trig_level_reg;
         rise_reg       <= trig_level_reg & ~level_prev_reg;
         if (!mismatch || filt_done) begin
            filt_cnt_reg <= '0;
         end else begin
            filt_cnt_reg <= filt_cnt_reg + FCW'(1);
         end
         if (filt_done) begin
            trig_level_reg <= trig_s;
         end
      end
   end

   // FSM state and holdoff counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_WAITLOW;
         hold_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   // Next-state logic and state-decoded outputs; start/armed drop as soon as reset asserts.
   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      start_int     = 1'b0;
      armed_int     = 1'b0;
      case (state_reg)
         S_WAITLOW: begin
            if (!trig_level_reg) state_next = S_ARMED;
         end
         S_ARMED: begin
            armed_int = 1'b1;
            if (rise_reg) state_next = S_FIRE;
         end
         S_FIRE: begin
            start_int  = 1'b1;
            state_next = S_BUSY;
         end
         S_BUSY: begin
            if (!bus.seq_busy) begin
               if (HOLDOFF_CYCLES == 0) begin
                  state_next = S_WAITLOW;
               end else begin
                  state_next    = S_HOLDOFF;
                  hold_cnt_next = 32'(HOLDOFF_CYCLES - 1);
               end
            end
         end
         S_HOLDOFF: begin
            if (hold_cnt_reg == '0) begin
               state_next = S_WAITLOW;
            end else begin
               hold_cnt_next = hold_cnt_reg - 32'd1;
            end
         end
         default: begin
            state_next = S_WAITLOW;
         end
      endcase
   end

   // A rise seen in any state but ARMED is a rejected trigger, including the rise
   // that coincides with entering ARMED.
   assign miss = rise_reg && (state_reg != S_ARMED);

   // Saturating miss counter; a clear in the same cycle as a miss leaves a count of one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_count_reg <= '0;
      end else if (bus.miss_clr) begin
         miss_count_reg <= miss ? MISS_W'(1) : '0;
      end else if (miss && (miss_count_reg != '1)) begin
         miss_count_reg <= miss_count_reg + MISS_W'(1);
      end
   end

   assign bus.start      = start_int;
   assign bus.armed      = armed_int;
   assign bus.trig_level = trig_level_reg;
   assign bus.miss_count = miss_count_reg;
endmodule

// File: tb/tb_trig_conditioner.sv
// Testbench for trig_conditioner: a table of timed vectors, hand-written corner
// sequences, and a randomized run, all cross-checked every cycle against a
// window-based behavioural model of the trigger path.
module tb_trig_conditioner;
   localparam int SYNC = 2;
   localparam int FILT = 4;
   localparam int HOLD = 10;
   localparam int MW   = 4;

   localparam int PH_WAIT  = 0;
   localparam int PH_ARMED = 1;
   localparam int PH_FIRE  = 2;
   localparam int PH_BUSY  = 3;
   localparam int PH_DEAD  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   trig_conditioner_if #(.MISS_W(MW)) bus ();

   trig_conditioner #(
      .SYNC_STAGES   (SYNC),
      .FILT_CYCLES   (FILT),
      .HOLDOFF_CYCLES(HOLD),
      .MISS_W        (MW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural model ----------------
   // pin_q[k-1] is the pin value sampled at edge k after reset release; lvl_q[k-1]
   // is the filtered level after edge k. Before the first edge both read as 1.
   bit pin_q[$];
   bit lvl_q[$];
   int m_n;
   int m_phase;
   int m_dead_end;
   int m_miss;

   function automatic bit pin_at(int k);
      return (k < 1) ? 1'b1 : pin_q[k-1];
   endfunction

   function automatic bit lvl_at(int k);
      return (k < 1) ? 1'b1 : lvl_q[k-1];
   endfunction

   function automatic void model_reset();
      pin_q.delete();
      lvl_q.delete();
      m_n      = 0;
      m_phase  = PH_WAIT;
      m_dead_end = 0;
      m_miss   = 0;
   endfunction

   function automatic void model_edge(bit pin, bit busy, bit clr);
      int n;
      int nxt;
      bit cur;
      bit flip;
      bit rise;
      bit miss;
      m_n = m_n + 1;
      n   = m_n;
      pin_q.push_back(pin);
      cur = lvl_at(n - 1);
      // Level changes once the last FILT synchronised samples all disagree with it.
      flip = 1'b1;
      for (int j = 0; j < FILT; j++) begin
         if (pin_at(n - SYNC - j) == cur) flip = 1'b0;
      end
      // Edge flag visible at this edge: level rose two edges ago.
      rise = lvl_at(n - 2) && !lvl_at(n - 3);
      miss = rise && (m_phase != PH_ARMED);
      nxt  = m_phase;
      case (m_phase)
         PH_WAIT:  if (!cur) nxt = PH_ARMED;
         PH_ARMED: if (rise) nxt = PH_FIRE;
         PH_FIRE:  nxt = PH_BUSY;
         PH_BUSY: begin
            if (!busy) begin
               if (HOLD == 0) begin
                  nxt = PH_WAIT;
               end else begin
                  nxt = PH_DEAD;
                  m_dead_end = n + HOLD;
               end
            end
         end
         default:  if (n >= m_dead_end) nxt = PH_WAIT;
      endcase
      m_phase = nxt;
      lvl_q.push_back(flip ? !cur : cur);
      if (clr) m_miss = miss ? 1 : 0;
      else if (miss && m_miss < (1 << MW) - 1) m_miss = m_miss + 1;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: advance the model with the inputs present at the edge, then compare.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge(bus.trig_in, bus.seq_busy, bus.miss_clr);
      #1;
      chk("mdl_start", int'(bus.start), int'(m_phase == PH_FIRE));
      chk("mdl_armed", int'(bus.armed), int'(m_phase == PH_ARMED));
      chk("mdl_level", int'(bus.trig_level), int'(lvl_at(m_n)));
      chk("mdl_miss",  int'(bus.miss_count), m_miss);
   endtask

   task automatic do_reset(input bit trig);
      rst_n        = 1'b0;
      bus.trig_in  = trig;
      bus.seq_busy = 1'b0;
      bus.miss_clr = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Ticks until start (sel=0) or armed (sel=1) is high; returns limit on timeout.
   task automatic wait_high(input bit sel, input int limit, output int n);
      n = 0;
      while (n < limit && !(sel ? bus.armed : bus.start)) begin
         tick();
         n = n + 1;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit trig;
      bit busy;
      bit clr;
      int ncyc;
      bit e_start;
      bit e_armed;
      bit e_level;
      int e_miss;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int starts;
      int run_left;
      int busy_left;

      bus.trig_in  = 1'b0;
      bus.seq_busy = 1'b0;
      bus.miss_clr = 1'b0;
      model_reset();

      // trig busy clr ncyc | start armed level miss  (edge count after release)
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 5,  1'b0, 1'b0, 1'b1, 0}; // e5: level still 1
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 0}; // e6: level 0
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 0}; // e7: armed
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b0, 0}; // e10
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 7,  1'b0, 1'b1, 1'b1, 0}; // e17: one edge before start
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b1, 0}; // e18: start, 8 edges after rise
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 0}; // e19: single-cycle start
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 12, 1'b0, 1'b0, 1'b1, 0}; // e31
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 6,  1'b0, 1'b0, 1'b0, 0}; // e37: level falls
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 0}; // e38: holdoff begins
      tbl[10] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 0}; // e48: back to wait-low
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 0}; // e49: re-armed
      tbl[12] = '{1'b1, 1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b0, 0}; // 3-cycle glitch
      tbl[13] = '{1'b0, 1'b0, 1'b0, 8,  1'b0, 1'b1, 1'b0, 0}; // glitch rejected

      // Scenarios 1 and 2: reset release timing, first start, glitch rejection.
      do_reset(1'b0);
      chk("rst_level", int'(bus.trig_level), 1);
      chk("rst_armed", int'(bus.armed), 0);
      chk("rst_start", int'(bus.start), 0);
      chk("rst_miss",  int'(bus.miss_count), 0);
      for (int i = 0; i < 14; i++) begin
         bus.trig_in  = tbl[i].trig;
         bus.seq_busy = tbl[i].busy;
         bus.miss_clr = tbl[i].clr;
         for (int c = 0; c < tbl[i].ncyc; c++) tick();
         chk($sformatf("tbl%0d_start", i), int'(bus.start), int'(tbl[i].e_start));
         chk($sformatf("tbl%0d_armed", i), int'(bus.armed), int'(tbl[i].e_armed));
         chk($sformatf("tbl%0d_level", i), int'(bus.trig_level), int'(tbl[i].e_level));
         chk($sformatf("tbl%0d_miss", i),  int'(bus.miss_count), tbl[i].e_miss);
      end
      $display("scenario 1-2 done: checks=%0d errors=%0d", checks, errors);

      // Scenario 3: trigger during a long busy is a miss; rearm after holdoff.
      bus.trig_in = 1'b1;
      wait_high(1'b0, 20, n);
      chk("s3_latency", n, 8);
      bus.seq_busy = 1'b1;
      starts = 0;
      for (int i = 1; i <= 100; i++) begin
         bus.trig_in = (i < 20) || (i >= 50 && i < 60);
         tick();
         if (bus.start) starts = starts + 1;
      end
      chk("s3_busy_starts", starts, 0);
      chk("s3_miss", int'(bus.miss_count), 1);
      bus.seq_busy = 1'b0;
      wait_high(1'b1, 40, n);
      chk("s3_rearm", n, 12);
      $display("scenario 3 done: checks=%0d errors=%0d", checks, errors);

      // Scenario 4: trigger held high through reset release never fires by itself.
      do_reset(1'b1);
      starts = 0;
      repeat (30) begin
         tick();
         if (bus.start) starts = starts + 1;
      end
      chk("s4_nostart", starts, 0);
      chk("s4_not_armed", int'(bus.armed), 0);
      bus.trig_in = 1'b0;
      repeat (10) tick();
      chk("s4_armed", int'(bus.armed), 1);
      bus.trig_in = 1'b1;
      starts = 0;
      repeat (30) begin
         tick();
         if (bus.start) starts = starts + 1;
      end
      chk("s4_one_start", starts, 1);
      $display("scenario 4 done: checks=%0d errors=%0d", checks, errors);

      // Scenario 5: miss counter saturation and clear behaviour.
      do_reset(1'b0);
      repeat (7) tick();
      bus.trig_in = 1'b1;
      wait_high(1'b0, 20, n);
      chk("s5_latency", n, 8);
      bus.seq_busy = 1'b1;
      bus.trig_in  = 1'b0;
      repeat (10) tick();
      for (int p = 0; p < 17; p++) begin
         bus.trig_in = 1'b1;
         repeat (8) tick();
         bus.trig_in = 1'b0;
         repeat (8) tick();
      end
      chk("s5_sat", int'(bus.miss_count), 15);
      bus.miss_clr = 1'b1;
      tick();
      bus.miss_clr = 1'b0;
      chk("s5_clr", int'(bus.miss_count), 0);
      bus.trig_in = 1'b1;
      repeat (7) tick();
      chk("s5_pre_rise", int'(bus.miss_count), 0);
      bus.miss_clr = 1'b1;
      tick();
      bus.miss_clr = 1'b0;
      chk("s5_clr_rise", int'(bus.miss_count), 1);
      $display("scenario 5 done: checks=%0d errors=%0d", checks, errors);

      // Scenario 6: asynchronous reset during BUSY and during FIRE.
      do_reset(1'b0);
      wait_high(1'b1, 20, n);
      chk("s6_arm_a", n, 7);
      bus.trig_in = 1'b1;
      wait_high(1'b0, 20, n);
      chk("s6_lat_a", n, 8);
      bus.seq_busy = 1'b1;
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6_busy_start", int'(bus.start), 0);
      chk("s6_busy_armed", int'(bus.armed), 0);
      bus.seq_busy = 1'b0;
      bus.trig_in  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      wait_high(1'b1, 20, n);
      chk("s6_arm_b", n, 7);
      bus.trig_in = 1'b1;
      wait_high(1'b0, 20, n);
      chk("s6_lat_b", n, 8);
      rst_n = 1'b0;
      #1;
      chk("s6_fire_start", int'(bus.start), 0);
      chk("s6_fire_armed", int'(bus.armed), 0);
      bus.trig_in = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      wait_high(1'b1, 20, n);
      chk("s6_arm_c", n, 7);
      bus.trig_in = 1'b1;
      wait_high(1'b0, 20, n);
      chk("s6_lat_c", n, 8);
      $display("scenario 6 done: checks=%0d errors=%0d", checks, errors);

      // Randomized run: mixed glitches and clean pulses, a reactive sequencer,
      // occasional clears and resets, all checked against the model every cycle.
      do_reset(1'b0);
      run_left  = 0;
      busy_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if (run_left == 0) begin
            bus.trig_in = !bus.trig_in;
            run_left    = $urandom_range(1, 14);
         end
         run_left = run_left - 1;
         bus.miss_clr = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 799) == 0) begin
            rst_n        = 1'b0;
            bus.seq_busy = 1'b0;
            busy_left    = 0;
            tick();
            tick();
            rst_n = 1'b1;
         end
         tick();
         if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) bus.seq_busy = 1'b0;
         end
         if (bus.start) begin
            bus.seq_busy = 1'b1;
            busy_left    = $urandom_range(1, 40);
         end
      end
      bus.miss_clr = 1'b0;
      $display("random run done: checks=%0d errors=%0d", checks, errors);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
